// File: rtl/sad_accumulator_pkg.sv
// sad_accumulator_pkg: shared widths and state encoding for the SAD accumulator
package sad_accumulator_pkg;
  localparam int PIX_W = 8;
  localparam int SAD_W = 13;
  localparam int TAG_W = 32;
  localparam int NUM_PIX_MAX = 32;
  localparam int CNT_W = $clog2(NUM_PIX_MAX + 1);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/sad_accumulator_abs_diff.sv
// abs_diff: unsigned absolute difference of two pixels
module abs_diff
  import sad_accumulator_pkg::*;
(
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  output logic [PIX_W-1:0] diff
);
  always_comb diff = (a >= b) ? a - b : b - a;
endmodule

// File: rtl/sad_accumulator.sv
// sad_accumulator: sums |a-b| over NUM_PIX pixel pairs per tagged candidate
module sad_accumulator
  import sad_accumulator_pkg::*;
#(
  parameter int NUM_PIX = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_start,
  input  logic             start,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_a,
  input  logic [PIX_W-1:0] pix_b,
  output logic [SAD_W-1:0] sad_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             sad_valid,
  output logic             min_clear,
  output logic             busy
);
  logic [1:0] state;
  logic [SAD_W-1:0] acc, sum;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] tag_q;
  logic [PIX_W-1:0] diff;
  logic accept, last;
  abs_diff u_abs_diff (.a(pix_a), .b(pix_b), .diff(diff));
  always_comb begin
    accept = (state == ST_ACCUM) && pix_valid;
    last = accept && (cnt == CNT_W'(NUM_PIX - 1));
    sum = acc + SAD_W'(diff);
  end
  assign sad_valid = (state == ST_DONE);
  assign busy = (state != ST_IDLE);
  // Results are captured on the final beat so outputs hold steady until the next one.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_IDLE;
      acc <= '0;
      cnt <= '0;
      tag_q <= '0;
      sad_out <= '0;
      tag_out <= '0;
      min_clear <= 1'b0;
    end else begin
      min_clear <= frame_start;
      if (frame_start || (start && state == ST_IDLE)) begin
        state <= start ? ST_ACCUM : ST_IDLE;
        if (start) begin
          tag_q <= tag_in;
          acc <= '0;
          cnt <= '0;
        end
      end else if (accept) begin
        acc <= sum;
        cnt <= cnt + 1'b1;
        if (last) begin
          state <= ST_DONE;
          sad_out <= sum;
          tag_out <= tag_q;
        end
      end else if (state == ST_DONE) begin
        state <= ST_IDLE;
      end
    end
  end
endmodule
